// File: rtl/viterbi_chan_pkg.sv
// Shared types and helpers for the encoder-to-decoder channel model.
package viterbi_chan_pkg;

    // Error-pattern source selected by mode_i.
    typedef enum logic [1:0] {
        CH_PASS   = 2'd0,
        CH_RAND   = 2'd1,
        CH_BURST  = 2'd2,
        CH_PERIOD = 2'd3
    } chan_mode_t;

    // Right-shifting Galois feedback mask for x^16+x^14+x^13+x^11+1
    // (exponents 16,14,13,11 land on bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS_W16 = 16'hB400;

    // Width of the symbol and error counters.
    localparam int unsigned CT_W = 32;

    // Add 0..2 to a counter, clamping at all-ones instead of wrapping.
    function automatic logic [CT_W-1:0] sat_add(input logic [CT_W-1:0] a,
                                                input logic [1:0]      inc);
        logic [CT_W:0] sum;
        sum = {1'b0, a} + {{(CT_W-1){1'b0}}, inc};
        return sum[CT_W] ? {CT_W{1'b1}} : sum[CT_W-1:0];
    endfunction

    // Number of bits flipped by a 2-bit error mask.
    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR that steps only when advance is high; a zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module lfsr_galois #(
    parameter int unsigned  W    = 16,
    parameter logic [W-1:0] SEED = W'(1),
    parameter logic [W-1:0] TAPS = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;

    // Shift right and fold the feedback mask in whenever the LSB falls out as 1.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state <= INIT;
        end else if (advance) begin
            state <= {1'b0, state[W-1:1]} ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/conv_channel_err_inj.sv
// Channel model between convolutional encoder and Viterbi decoder: registers
// each 2-bit symbol, XORs in a reproducible error mask, and keeps saturating
// symbol / errored-symbol / flipped-bit counters for repeatable BER runs.
module conv_channel_err_inj
    import viterbi_chan_pkg::*;
#(
    parameter int unsigned       N         = 4,
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int unsigned       BURST_LEN = 4,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(LFSR_TAPS_W16),
    // Value the counters take on reset; clear_i always returns them to zero.
    parameter logic [CT_W-1:0]   CNT_INIT  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic [1:0]      d_in,
    input  logic [1:0]      mode_i,
    input  logic            clear_i,
    output logic            valid_o,
    output logic [1:0]      d_out,
    output logic [1:0]      err_mask_o,
    output logic [CT_W-1:0] sym_ct_o,
    output logic [CT_W-1:0] err_sym_ct_o,
    output logic [CT_W-1:0] err_bit_ct_o
);

    // Parameter sanity checks at elaboration.
    generate
        if (N < 1 || N > 12) begin : g_bad_n
            $error("conv_channel_err_inj: N must be 1..12");
        end
        if (LFSR_W < N + 2) begin : g_bad_w
            $error("conv_channel_err_inj: LFSR_W must be at least N+2");
        end
        if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
            $error("conv_channel_err_inj: BURST_LEN must be 1..255");
        end
    endgenerate

    // Burst FSM encoding.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Symbols still to corrupt after the triggering one.
    localparam logic [7:0]   BURST_REM   = 8'(BURST_LEN - 1);
    localparam logic [N-1:0] PERIOD_LAST = '1;

    chan_mode_t        mode;
    logic [LFSR_W-1:0] lfsr_state;
    logic              lfsr_unused;
    logic              trig;
    logic [1:0]        rand_bits;
    logic [1:0]        mask;

    logic [0:0]        burst_state_q;
    logic [0:0]        burst_state_d;
    logic [7:0]        burst_cnt_q;
    logic [7:0]        burst_cnt_d;

    logic [CT_W-1:0]   sym_ct_q;
    logic [CT_W-1:0]   err_sym_ct_q;
    logic [CT_W-1:0]   err_bit_ct_q;

    assign mode = chan_mode_t'(mode_i);

    // Pattern source; advances once per accepted symbol so the error
    // pattern depends only on the symbol index, not on idle gaps.
    lfsr_galois #(
        .W    (LFSR_W),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (enable_i),
        .state   (lfsr_state)
    );

    // Only the low N+2 bits steer decisions; the rest just feed the shift.
    assign lfsr_unused = ^lfsr_state;

    // Decisions use the LFSR value before this symbol advances it.
    assign trig      = (lfsr_state[N-1:0] == '0);
    assign rand_bits = lfsr_state[N+1:N];

    // Mask selection and burst next-state: abort on mode exit, clear wins last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        mask          = 2'b00;
        burst_state_d = burst_state_q;
        burst_cnt_d   = burst_cnt_q;

        case (mode)
            CH_PASS: begin
                mask = 2'b00;
            end
            CH_RAND: begin
                if (trig) begin
                    mask = (rand_bits == 2'b00) ? 2'b01 : rand_bits;
                end
            end
            CH_BURST: begin
                // Gaps (enable_i low) neither start nor consume a burst.
                if (enable_i) begin
                    if (burst_state_q == ST_ACTIVE) begin
                        mask        = 2'b11;
                        burst_cnt_d = burst_cnt_q - 8'd1;
                        if (burst_cnt_q == 8'd1) begin
                            burst_state_d = ST_IDLE;
                        end
                    end else if (trig) begin
                        mask          = 2'b11;
                        burst_cnt_d   = BURST_REM;
                        burst_state_d = (BURST_REM == 8'd0) ? ST_IDLE : ST_ACTIVE;
                    end
                end
            end
            CH_PERIOD: begin
                // Pre-increment count: indices 2^N-1, 2*2^N-1, ... are hit.
                if (sym_ct_q[N-1:0] == PERIOD_LAST) begin
                    mask = 2'b01;
                end
            end
            default: begin
                mask = 2'b00;
            end
        endcase

        // Leaving burst mode drops any burst in progress in the same cycle.
        if (mode != CH_BURST) begin
            burst_state_d = ST_IDLE;
            burst_cnt_d   = 8'd0;
        end

        if (clear_i) begin
            burst_state_d = ST_IDLE;
            burst_cnt_d   = 8'd0;
        end
    end

    // Burst FSM state and remaining-symbol count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_state_q <= ST_IDLE;
            burst_cnt_q   <= 8'd0;
        end else begin
            burst_state_q <= burst_state_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

    // Output register: data and mask hold across idle cycles, valid follows enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o    <= 1'b0;
            d_out      <= 2'b00;
            err_mask_o <= 2'b00;
        end else begin
            valid_o <= enable_i;
            if (enable_i) begin
                d_out      <= d_in ^ mask;
                err_mask_o <= mask;
            end
        end
    end

    // Saturating counters; a coincident clear discards the symbol's count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_ct_q     <= CNT_INIT;
            err_sym_ct_q <= CNT_INIT;
            err_bit_ct_q <= CNT_INIT;
        end else if (clear_i) begin
            sym_ct_q     <= '0;
            err_sym_ct_q <= '0;
            err_bit_ct_q <= '0;
        end else if (enable_i) begin
            sym_ct_q     <= sat_add(sym_ct_q, 2'd1);
            err_sym_ct_q <= sat_add(err_sym_ct_q, {1'b0, |mask});
            err_bit_ct_q <= sat_add(err_bit_ct_q, popcount2(mask));
        end
    end

    assign sym_ct_o     = sym_ct_q;
    assign err_sym_ct_o = err_sym_ct_q;
    assign err_bit_ct_o = err_bit_ct_q;

endmodule

// File: tb/tb_conv_channel_err_inj.sv
// Directed bench for conv_channel_err_inj: a bit-exact channel model pushes
// expected symbols into a scoreboard queue as stimulus is driven; they are
// popped and compared when the DUT presents valid output.
module tb_conv_channel_err_inj;
    import viterbi_chan_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned BL = 3;

    typedef struct packed {
        logic [1:0] d;
        logic [1:0] m;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        enable_i = 1'b0;
    logic        clear_i  = 1'b0;
    logic [1:0]  d_in     = 2'b00;
    logic [1:0]  mode_i   = 2'b00;
    logic [1:0]  sat_mode = 2'b00;

    logic        valid_o;
    logic [1:0]  d_out;
    logic [1:0]  err_mask_o;
    logic [31:0] sym_ct_o;
    logic [31:0] err_sym_ct_o;
    logic [31:0] err_bit_ct_o;

    logic        s_valid;
    logic [1:0]  s_d_out;
    logic [1:0]  s_mask;
    logic [31:0] s_sym;
    logic [31:0] s_esym;
    logic [31:0] s_ebit;

    int total = 0;
    int bad   = 0;

    // Scoreboards and channel model state.
    exp_t        exp_q[$];
    logic [1:0]  sat_q[$];
    exp_t        last_e;
    logic [15:0] m_lfsr;
    int          m_brem;
    logic [31:0] m_sym;
    logic [31:0] m_esym;
    logic [31:0] m_ebit;
    logic [1:0]  m_last_mask;
    int          bursts;

    logic        en_v;
    int          run_len;
    logic [1:0]  run_mask [400];

    conv_channel_err_inj #(
        .N         (N),
        .LFSR_W    (16),
        .SEED      (16'hACE1),
        .BURST_LEN (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .d_in         (d_in),
        .mode_i       (mode_i),
        .clear_i      (clear_i),
        .valid_o      (valid_o),
        .d_out        (d_out),
        .err_mask_o   (err_mask_o),
        .sym_ct_o     (sym_ct_o),
        .err_sym_ct_o (err_sym_ct_o),
        .err_bit_ct_o (err_bit_ct_o)
    );

    // Second instance preset near the top of the counter range; periodic
    // mode with N=1 corrupts every odd-indexed symbol.
    conv_channel_err_inj #(
        .N        (1),
        .CNT_INIT (32'hFFFF_FFFD)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .d_in         (d_in),
        .mode_i       (sat_mode),
        .clear_i      (clear_i),
        .valid_o      (s_valid),
        .d_out        (s_d_out),
        .err_mask_o   (s_mask),
        .sym_ct_o     (s_sym),
        .err_sym_ct_o (s_esym),
        .err_bit_ct_o (s_ebit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // x^16+x^14+x^13+x^11+1, right-shifting Galois form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic model_reset();
        m_lfsr      = 16'hACE1;
        m_brem      = 0;
        m_sym       = '0;
        m_esym      = '0;
        m_ebit      = '0;
        m_last_mask = 2'b00;
        last_e      = '0;
    endtask

    task automatic apply_reset();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        enable_i = 1'b0;
        clear_i  = 1'b0;
        d_in     = 2'b00;
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_dout",  32'(d_out), 32'd0);
        check("rst_mask",  32'(err_mask_o), 32'd0);
        check("rst_sym",   sym_ct_o, 32'd0);
        check("rst_esym",  err_sym_ct_o, 32'd0);
        check("rst_ebit",  err_bit_ct_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
    endtask

    // Drive one cycle on the main DUT, run the model, and compare after the edge.
    task automatic step(input logic [1:0] m, input logic [1:0] d, input logic en, input logic clr);
        exp_t       e;
        logic [1:0] msk;
        logic       trig;
        msk = 2'b00;
        @(negedge clk);
        mode_i   = m;
        d_in     = d;
        enable_i = en;
        clear_i  = clr;
        trig = (m_lfsr[N-1:0] == '0);
        if (en) begin
            case (m)
                CH_RAND:   if (trig) msk = (m_lfsr[N+1:N] == 2'b00) ? 2'b01 : m_lfsr[N+1:N];
                CH_BURST: begin
                    if (m_brem > 0) begin
                        msk = 2'b11;
                        m_brem--;
                    end else if (trig) begin
                        msk    = 2'b11;
                        m_brem = BL - 1;
                        bursts++;
                    end
                end
                CH_PERIOD: if (m_sym[N-1:0] == '1) msk = 2'b01;
                default:   msk = 2'b00;
            endcase
            e.d = d ^ msk;
            e.m = msk;
            exp_q.push_back(e);
            m_lfsr = lfsr_next(m_lfsr);
        end
        if (m != CH_BURST || clr) m_brem = 0;
        if (clr) begin
            m_sym  = '0;
            m_esym = '0;
            m_ebit = '0;
        end else if (en) begin
            m_sym  = m_sym + 32'd1;
            m_esym = m_esym + ((msk != 2'b00) ? 32'd1 : 32'd0);
            m_ebit = m_ebit + 32'(msk[1]) + 32'(msk[0]);
        end
        m_last_mask = msk;
        @(posedge clk);
        #1;
        check("valid", 32'(valid_o), 32'(en));
        if (valid_o === 1'b1 && exp_q.size() != 0) last_e = exp_q.pop_front();
        check("dout",     32'(d_out), 32'(last_e.d));
        check("mask",     32'(err_mask_o), 32'(last_e.m));
        check("sym_ct",   sym_ct_o, m_sym);
        check("esym_ct",  err_sym_ct_o, m_esym);
        check("ebit_ct",  err_bit_ct_o, m_ebit);
    endtask

    // One valid symbol on the saturation instance with fixed expectations.
    task automatic sat_step(input logic [1:0] d, input logic clr, input logic [1:0] exp_d,
                            input logic [31:0] e_sym, input logic [31:0] e_esym,
                            input logic [31:0] e_ebit);
        @(negedge clk);
        mode_i   = CH_PASS;
        sat_mode = CH_PERIOD;
        d_in     = d;
        enable_i = 1'b1;
        clear_i  = clr;
        sat_q.push_back(exp_d);
        @(posedge clk);
        #1;
        check("sat_valid", 32'(s_valid), 32'd1);
        if (s_valid === 1'b1 && sat_q.size() != 0) check("sat_dout", 32'(s_d_out), 32'(sat_q.pop_front()));
        check("sat_sym",  s_sym, e_sym);
        check("sat_esym", s_esym, e_esym);
        check("sat_ebit", s_ebit, e_ebit);
    endtask

    initial begin
        bursts = 0;
        model_reset();
        apply_reset();

        // Pass-through: 100 symbols of 10.
        for (int i = 0; i < 100; i++) begin
            step(CH_PASS, 2'b10, 1'b1, 1'b0);
            check("pass_dout", 32'(d_out), 32'd2);
        end
        check("pass_sym",  sym_ct_o, 32'd100);
        check("pass_esym", err_sym_ct_o, 32'd0);
        check("pass_ebit", err_bit_ct_o, 32'd0);

        // Clear without a symbol, then periodic mode over 64 zero symbols.
        step(CH_PASS, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            step(CH_PERIOD, 2'b00, 1'b1, 1'b0);
            check("per_dout", 32'(d_out), ((i % 16) == 15) ? 32'd1 : 32'd0);
        end
        check("per_sym",  sym_ct_o, 32'd64);
        check("per_esym", err_sym_ct_o, 32'd4);
        check("per_ebit", err_bit_ct_o, 32'd4);

        // Burst mode with enable gaps; drain any burst still open at the end.
        step(CH_PASS, 2'b00, 1'b0, 1'b1);
        bursts = 0;
        for (int i = 0; i < 240; i++) begin
            en_v = ((i % 5) != 2) && ((i % 7) != 4);
            step(CH_BURST, 2'(i), en_v, 1'b0);
        end
        for (int k = 0; k < 8 && m_brem != 0; k++) step(CH_BURST, 2'b01, 1'b1, 1'b0);
        check("burst_ebit", err_bit_ct_o, 32'(6 * bursts));
        check("burst_esym", err_sym_ct_o, 32'(3 * bursts));

        // Random mode from SEED over 10000 symbols.
        apply_reset();
        for (int i = 0; i < 10000; i++) step(CH_RAND, 2'($urandom), 1'b1, 1'b0);
        check("rand_sym", sym_ct_o, 32'd10000);
        check("rand_rate_in_band", 32'((err_sym_ct_o >= 32'd563) && (err_sym_ct_o <= 32'd687)), 32'd1);

        // Reset in the middle of a burst, then replay the same stimulus.
        apply_reset();
        run_len = 0;
        for (int i = 0; i < 400; i++) begin
            en_v = ((i % 4) != 3);
            step(CH_BURST, 2'(i), en_v, 1'b0);
            run_mask[i] = m_last_mask;
            run_len = i + 1;
            if (i >= 20 && m_brem != 0) break;
        end
        apply_reset();
        for (int i = 0; i < run_len; i++) begin
            en_v = ((i % 4) != 3);
            step(CH_BURST, 2'(i), en_v, 1'b0);
            if (en_v) check("replay_mask", 32'(err_mask_o), 32'(run_mask[i]));
        end

        // Saturation from the preset, then clear against a valid symbol.
        apply_reset();
        check("sat_rst_sym", s_sym, 32'hFFFF_FFFD);
        sat_step(2'b10, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        sat_step(2'b10, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        sat_step(2'b00, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sat_step(2'b11, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apply_reset();
        sat_step(2'b01, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        sat_step(2'b01, 1'b1, 2'b01, 32'd0, 32'd0, 32'd0);
        sat_step(2'b11, 1'b0, 2'b11, 32'd1, 32'd0, 32'd0);
        sat_step(2'b00, 1'b0, 2'b01, 32'd2, 32'd1, 32'd1);
        check("sat_sb_drain", 32'(sat_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_channel_err_inj.md
# conv_channel_err_inj

Deterministic channel model between the convolutional encoder and the Viterbi decoder. It registers each 2-bit encoder symbol and optionally corrupts it with a reproducible error pattern. Pattern sources are LFSR-random, LFSR-triggered burst, or fixed-period. It keeps symbol and error counters so BER runs are repeatable without `$random`.

## Interface
- `N`, default 4: error trigger probability 2^-N per symbol (random/burst modes); period 2^N symbols (periodic mode). Range 1..12.
- `LFSR_W`, default 16: LFSR width; must be ≥ N+2.
- `SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 1.
- `BURST_LEN`, default 4: consecutive corrupted symbols per burst, 1..255.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `enable_i`  in  1  `d_in` valid (encoder `valid_o`)
- `d_in`  in  2  encoder symbol
- `mode_i`  in  2  0 pass, 1 random, 2 burst, 3 periodic; sampled every cycle
- `clear_i`  in  1  synchronous clear of counters and burst state
- `valid_o`  out  1  `d_out` valid (feeds decoder enable)
- `d_out`  out  2  `d_in` XOR mask
- `err_mask_o`  out  2  mask applied to current `d_out`
- `sym_ct_o`  out  32  symbols passed
- `err_sym_ct_o`  out  32  symbols with nonzero mask
- `err_bit_ct_o`  out  32  total flipped bits

## Operation
- LFSR: Galois, taps x^16+x^14+x^13+x^11+1 for W=16. It advances only on cycles with `enable_i`=1. Decisions use the pre-advance value.
- trig = (lfsr[N-1:0] == 0).
- Mode 0: mask 00.
- Mode 1: on trig, mask = lfsr[N+1:N]; 00 is promoted to 01. Otherwise mask 00.
- Mode 2: idle, trig starts a burst. The triggering symbol plus BURST_LEN-1 following valid symbols get mask 11. Triggers during a burst are ignored. Burst counter decrements only on valid symbols.
- Mode 3: mask 01 when sym_ct[N-1:0] == 2^N-1. Uses the pre-increment count, so symbol indices 2^N-1, 2·2^N-1, … are corrupted.
- Leaving mode 2 while a burst is active aborts the burst (counter → 0) in that cycle.
- Counters update only on valid symbols and saturate at 32'hFFFF_FFFF. err_bit_ct adds popcount(mask), 0..2.
- `clear_i`=1 zeroes all three counters and the burst counter. LFSR is unaffected. If `clear_i` and `enable_i` are both high, clear wins and the symbol is not counted; the symbol itself is still output normally.

## Timing
- Latency 1 cycle: `d_in`/`enable_i` at edge k → `d_out`/`valid_o`/`err_mask_o` after edge k+1.
- With `enable_i`=0: `valid_o`=0, `d_out` and `err_mask_o` hold their last values, LFSR and counters hold.
- Back-to-back valid symbols are accepted every cycle; there is no backpressure.
- Reset values: `valid_o`=0, `d_out`=00, `err_mask_o`=00, all counters 0, burst counter 0, LFSR=SEED (1 if SEED=0).
- Reset mid-burst: burst is lost; after release, operation restarts from SEED, so the pattern repeats exactly.
- `mode_i` change takes effect on the first valid symbol sampled with the new value.

## Structure
- Package `viterbi_chan_pkg`:
  - `chan_mode_t` enum: CH_PASS, CH_RAND, CH_BURST, CH_PERIOD.
  - LFSR tap constant for W=16.
  - Saturating-increment function.
- Sub-module `lfsr_galois`, parameterised by W, SEED, TAPS, with an `advance` input and `state` output.
- Top level holds the mask mux, burst FSM (IDLE/ACTIVE), output register and counters.

## Test plan
- Mode 0, 100 valid symbols of d_in=10 → d_out=10 every valid cycle; sym_ct=100, err_sym_ct=0, err_bit_ct=0.
- Mode 3, N=4, 64 symbols of 00 → d_out=01 only at symbol indices 15, 31, 47, 63; err_sym_ct=4, err_bit_ct=4.
- Mode 2, BURST_LEN=3, with `enable_i` gaps inserted mid-burst → exactly 3 valid symbols per burst carry 11; gaps do not consume the burst; err_bit_ct = 6 × burst count.
- Mode 1, SEED=16'hACE1, 10000 symbols → `d_out` and counters match a bit-exact bench LFSR model; err_sym_ct ≈ 625 ±10%.
- Asserting `rst` mid-burst, then replaying the identical stimulus → identical mask sequence from symbol 0; all outputs 0 during reset.
- `clear_i` coincident with valid symbol when counters are at 32'hFFFF_FFFE → counters 0 next cycle; with no clear, saturation at FFFF_FFFF verified.
